// File: rtl/muldiv_types_pkg.sv
// Shared types for the M-extension multiply sequencer: funct3 opcodes, FSM states,
// product kinds and counter sizing.
package muldiv_types_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

    typedef enum logic [1:0] {
        UU,
        SS,
        SU
    } prod_kind_t;

    localparam int MUL_CYCLES_DEFAULT = 3;
    localparam int MUL_CNT_W          = $clog2(MUL_CYCLES_DEFAULT + 1);

    function automatic int mul_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    // MUL only needs the low word, which is identical for every kind, so it runs as UU.
    function automatic prod_kind_t kind_of(input mul_op_t op);
        prod_kind_t kind;
        case (op)
            OP_MULH:   kind = SS;
            OP_MULHSU: kind = SU;
            default:   kind = UU;
        endcase
        return kind;
    endfunction

    function automatic logic [31:0] select_word(input mul_op_t op, input logic [63:0] prod);
        return (op == OP_MUL) ? prod[31:0] : prod[63:32];
    endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Request/response bundle between the EX stage and the multiply sequencer.
interface mul_ctrl_if;

    logic        req_i;
    logic        flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        busy_o;
    logic        resp_valid_o;
    logic [31:0] result_o;

    modport master (
        output req_i, flush_i, funct3_i, rs1_i, rs2_i,
        input  busy_o, resp_valid_o, result_o
    );

    modport slave (
        input  req_i, flush_i, funct3_i, rs1_i, rs2_i,
        output busy_o, resp_valid_o, result_o
    );

endinterface

// File: rtl/mul_ctrl_mult.sv
// Combinational 32x32 multiplier; sign=1 treats both operands as two's complement.
// Timed as a multicycle path by the sequencer.
module mul_ctrl_mult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign,
    output logic [63:0] product
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;

    // Extending to 64 bits makes the low 64 bits of the product exact modulo 2^64.
    assign a_ext   = {{32{sign & a[31]}}, a};
    assign b_ext   = {{32{sign & b[31]}}, b};
    assign product = a_ext * b_ext;

endmodule

// File: rtl/mul_ctrl.sv
// Multicycle sequencer around the EX-stage multiplier with a one-entry product cache
// so MULH[U]/MUL pairs on the same operands share one computation.
module mul_ctrl
    import muldiv_types_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    mul_ctrl_if.slave bus
);

    localparam int             CNT_W    = mul_cnt_width(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_t       state_q;
    mul_state_t       state_d;

    logic [31:0]      op_a_q;
    logic [31:0]      op_b_q;
    mul_op_t          op_fn_q;
    logic [CNT_W-1:0] cnt_q;

    logic             cache_valid_q;
    logic [31:0]      cache_a_q;
    logic [31:0]      cache_b_q;
    prod_kind_t       cache_kind_q;
    logic [63:0]      cache_prod_q;

    logic             busy_q;
    logic             resp_q;
    logic [31:0]      result_q;

    mul_op_t          req_op;
    prod_kind_t       req_kind;
    prod_kind_t       op_kind;
    logic             accept;
    logic             cache_hit;
    logic             capture;
    logic [63:0]      raw_prod;
    logic [31:0]      su_corr;
    logic [63:0]      final_prod;

    assign req_op   = mul_op_t'({1'b0, bus.funct3_i[1:0]});
    assign req_kind = kind_of(req_op);
    assign op_kind  = kind_of(op_fn_q);
    assign accept   = bus.req_i & ~bus.funct3_i[2] & ~bus.flush_i;

    assign cache_hit = cache_valid_q
                     && (cache_a_q == bus.rs1_i)
                     && (cache_b_q == bus.rs2_i)
                     && ((req_op == OP_MUL) || (cache_kind_q == req_kind));

    // Flush wins over a capture landing on the same edge.
    assign capture = (state_q == BUSY) && (cnt_q == CNT_LAST) && !bus.flush_i;

    mul_ctrl_mult u_mult (
        .a       (op_a_q),
        .b       (op_b_q),
        .sign    (op_kind == SS),
        .product (raw_prod)
    );

    // Signed-by-unsigned from an unsigned product: a negative a overcounts by b * 2^32.
    assign su_corr    = ((op_kind == SU) && op_a_q[31]) ? op_b_q : 32'd0;
    assign final_prod = {raw_prod[63:32] - su_corr, raw_prod[31:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = cache_hit ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (capture) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) begin
            state_d = IDLE;
        end
    end

    // Operands are sampled once on a miss; the multiplier never sees the live bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            op_fn_q <= OP_MUL;
            cnt_q   <= '0;
        end else if ((state_q == IDLE) && accept && !cache_hit) begin
            op_a_q  <= bus.rs1_i;
            op_b_q  <= bus.rs2_i;
            op_fn_q <= req_op;
            cnt_q   <= '0;
        end else if (state_q == BUSY) begin
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid_q <= 1'b0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_kind_q  <= UU;
            cache_prod_q  <= '0;
        end else if (capture) begin
            cache_valid_q <= 1'b1;
            cache_a_q     <= op_a_q;
            cache_b_q     <= op_b_q;
            cache_kind_q  <= op_kind;
            cache_prod_q  <= final_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            resp_q   <= 1'b0;
            result_q <= '0;
        end else begin
            busy_q <= (state_d == BUSY);
            resp_q <= (state_d == DONE);
            if (capture) begin
                result_q <= select_word(op_fn_q, final_prod);
            end else if ((state_q == IDLE) && accept && cache_hit) begin
                result_q <= select_word(req_op, cache_prod_q);
            end
        end
    end

    assign bus.busy_o       = busy_q;
    assign bus.resp_valid_o = resp_q;
    assign bus.result_o     = result_q;

endmodule
